// File: rtl/block_splitter.sv
// Splits one packed word of up to 2*MAX_NUM_BLOCKS blocks into two lanes (low blocks / re-based remainder).
// Latency: 1 cycle from input accept to out_valid; full throughput when both lanes are ready.
// Backpressure: in_ready only when both lanes are free; a stalled lane holds its outputs stable.
// Optional build macro BLOCK_SPLITTER_ZERO_FILL_EN: zero the block slots at or above out_num in each lane.
module block_splitter #(
    parameter int BLOCK_SIZE     = 64,
    parameter int MAX_NUM_BLOCKS = 1
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    output logic                                         in_ready,
    input  logic [2*MAX_NUM_BLOCKS*BLOCK_SIZE-1:0]       in_data,
    input  logic                                         in_valid,
    input  logic [31:0]                                  in_num,
    input  logic                                         in_last,
    input  logic [1:0]                                   out_ready,
    output logic [1:0][MAX_NUM_BLOCKS*BLOCK_SIZE-1:0]    out_data,
    output logic [1:0]                                   out_valid,
    output logic [1:0][31:0]                             out_num,
    output logic [1:0]                                   out_last,
    output logic                                         err_overflow
);
    localparam int          LW    = MAX_NUM_BLOCKS * BLOCK_SIZE;
    localparam logic [31:0] MAX_N = 32'(MAX_NUM_BLOCKS);
    localparam logic [31:0] TOT_N = 32'(2 * MAX_NUM_BLOCKS);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} lane_state_t;

    lane_state_t            state_q [2];
    lane_state_t            state_d [2];
    logic [1:0]             free;
    logic                   accept;
    logic                   overflow;
    logic [31:0]            n, n0, n1;
    logic [1:0][31:0]       lane_num;
    logic [1:0][LW-1:0]     lane_data;
    logic [1:0]             load;

    // Handshake and per-lane split of the incoming beat; counts compared at full 32 bits.
    always_comb begin
        free      = ~out_valid | out_ready;
        in_ready  = rst_n & free[0] & free[1];
        accept    = in_valid & in_ready;
        overflow  = in_num > TOT_N;
        n         = overflow ? TOT_N : in_num;
        n0        = (n > MAX_N) ? MAX_N : n;
        n1        = n - n0;
        lane_num[0]  = n0;
        lane_num[1]  = n1;
        lane_data[0] = in_data[LW-1:0];
        lane_data[1] = in_data[2*LW-1:LW];
`ifdef BLOCK_SPLITTER_ZERO_FILL_EN
        for (int k = 0; k < 2; k++) begin
            for (int b = 0; b < MAX_NUM_BLOCKS; b++) begin
                if (32'(b) >= lane_num[k]) begin
                    lane_data[k][b*BLOCK_SIZE +: BLOCK_SIZE] = '0;
                end
            end
        end
`endif
        // A lane only produces a beat if it gets blocks or must carry the last flag.
        for (int k = 0; k < 2; k++) begin
            load[k] = (lane_num[k] != 32'd0) | in_last;
        end
    end

    // Per-lane EMPTY/FULL next state; an accept overrides a simultaneous drain.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            out_valid[k] = (state_q[k] == FULL);
            state_d[k]   = state_q[k];
            if (accept) begin
                state_d[k] = load[k] ? FULL : EMPTY;
            end else if (out_ready[k]) begin
                state_d[k] = EMPTY;
            end
        end
    end

    // Lane state registers.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                state_q[k] <= EMPTY;
            end else begin
                state_q[k] <= state_d[k];
            end
        end
    end

    // Lane payload registers and sticky overflow; unloaded lanes keep their payload.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data     <= '0;
            out_num      <= '0;
            out_last     <= '0;
            err_overflow <= 1'b0;
        end else if (accept) begin
            for (int k = 0; k < 2; k++) begin
                if (load[k]) begin
                    out_data[k] <= lane_data[k];
                    out_num[k]  <= lane_num[k];
                    out_last[k] <= in_last;
                end
            end
            if (overflow) begin
                err_overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_block_splitter.sv
// Self-checking bench for block_splitter with MAX_NUM_BLOCKS=2, BLOCK_SIZE=8.
// Directed scenarios plus randomized traffic against a lane-content reference model.
// Inputs change on the falling edge; outputs are compared 1ns later.
module tb_block_splitter;
    localparam int BS = 8;
    localparam int M  = 2;
    localparam int LW = M * BS;
    localparam int DW = 2 * LW;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  in_ready;
    logic [DW-1:0]         in_data = '0;
    logic                  in_valid = 1'b0;
    logic [31:0]           in_num = '0;
    logic                  in_last = 1'b0;
    logic [1:0]            out_ready = '0;
    logic [1:0][LW-1:0]    out_data;
    logic [1:0]            out_valid;
    logic [1:0][31:0]      out_num;
    logic [1:0]            out_last;
    logic                  err_overflow;

    int errors = 0;
    int checks = 0;
    int beats [2];

    // Reference model: what each lane is expected to be presenting.
    logic [1:0]    m_vld;
    logic [31:0]   m_num [2];
    logic [LW-1:0] m_dat [2];
    logic [1:0]    m_last;
    logic          m_err;

    block_splitter #(.BLOCK_SIZE(BS), .MAX_NUM_BLOCKS(M)) dut (
        .clk(clk), .rst_n(rst_n), .in_ready(in_ready), .in_data(in_data),
        .in_valid(in_valid), .in_num(in_num), .in_last(in_last),
        .out_ready(out_ready), .out_data(out_data), .out_valid(out_valid),
        .out_num(out_num), .out_last(out_last), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Slots at or above num are only defined in the zero-fill build.
    function automatic logic [LW-1:0] slot_mask(input logic [31:0] num);
        logic [LW-1:0] m;
        m = '0;
        for (int j = 0; j < M; j++) begin
`ifdef BLOCK_SPLITTER_ZERO_FILL_EN
            m[j*BS +: BS] = '1;
`else
            if (32'(j) < num) m[j*BS +: BS] = '1;
`endif
        end
        return m;
    endfunction

    task automatic compare();
        logic exp_rdy;
        exp_rdy = (!m_vld[0] || out_ready[0]) && (!m_vld[1] || out_ready[1]);
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("err_overflow", 64'(err_overflow), 64'(m_err));
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("out_valid[%0d]", k), 64'(out_valid[k]), 64'(m_vld[k]));
            if (m_vld[k]) begin
                chk($sformatf("out_num[%0d]", k), 64'(out_num[k]), 64'(m_num[k]));
                chk($sformatf("out_last[%0d]", k), 64'(out_last[k]), 64'(m_last[k]));
                chk($sformatf("out_data[%0d]", k), 64'(out_data[k] & slot_mask(m_num[k])),
                    64'(m_dat[k] & slot_mask(m_num[k])));
            end
            if (out_valid[k] && out_ready[k]) beats[k]++;
        end
    endtask

    // One clock: drive inputs, compare current outputs, then advance the model past the edge.
    task automatic cycle(input logic iv, input logic [31:0] num, input logic [DW-1:0] d,
                         input logic lst, input logic [1:0] ordy);
        logic          exp_rdy;
        logic [31:0]   nn;
        logic [31:0]   cnt [2];
        @(negedge clk);
        in_valid = iv; in_num = num; in_data = d; in_last = lst; out_ready = ordy;
        #1;
        compare();
        exp_rdy = (!m_vld[0] || ordy[0]) && (!m_vld[1] || ordy[1]);
        if (iv && exp_rdy) begin
            if (num > 32'(2 * M)) m_err = 1'b1;
            nn = (num > 32'(2 * M)) ? 32'(2 * M) : num;
            cnt[0] = (nn > 32'(M)) ? 32'(M) : nn;
            cnt[1] = nn - cnt[0];
            for (int k = 0; k < 2; k++) begin
                if (cnt[k] != 0 || lst) begin
                    m_vld[k] = 1'b1;
                    m_num[k] = cnt[k];
                    m_last[k] = lst;
                    for (int j = 0; j < M; j++) begin
                        if (32'(j) < cnt[k]) m_dat[k][j*BS +: BS] = d[(k*M + j)*BS +: BS];
                        else                 m_dat[k][j*BS +: BS] = '0;
                    end
                end else begin
                    m_vld[k] = 1'b0;
                end
            end
        end else begin
            for (int k = 0; k < 2; k++) if (ordy[k]) m_vld[k] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 2'b00;
        #1;
        chk("in_ready_in_reset", 64'(in_ready), 64'd0);
        @(negedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_num", 64'(out_num), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_err", 64'(err_overflow), 64'd0);
        m_vld = '0; m_last = '0; m_err = 1'b0;
        for (int k = 0; k < 2; k++) begin m_num[k] = '0; m_dat[k] = '0; end
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] rn;
        int r;
        do_reset();

        // Split 3 blocks A,B,C (+ junk X): lane0 gets A,B, lane1 gets C.
        cycle(1'b1, 32'd3, 32'hD4C3B2A1, 1'b0, 2'b11);
        cycle(1'b0, 32'd0, '0, 1'b0, 2'b11);
        chk("split_lane0_data", 64'(out_data[0]), 64'h0000_B2A1);
`ifdef BLOCK_SPLITTER_ZERO_FILL_EN
        chk("split_lane1_data", 64'(out_data[1]), 64'h0000_00C3);
`else
        chk("split_lane1_blk0", 64'(out_data[1][BS-1:0]), 64'h0000_00C3);
`endif

        // Single block, then an empty last beat on both lanes.
        cycle(1'b1, 32'd1, 32'h11223344, 1'b0, 2'b11);
        cycle(1'b1, 32'd0, 32'h55667788, 1'b1, 2'b11);
        cycle(1'b0, 32'd0, '0, 1'b0, 2'b00);
        chk("empty_last_flags", 64'(out_last), 64'h3);

        // Lane1 stalled: in_ready low, lane0 drains, lane1 holds; release restores ready.
        cycle(1'b0, 32'd0, '0, 1'b0, 2'b11);
        cycle(1'b1, 32'd4, 32'hCAFEF00D, 1'b0, 2'b11);
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'd4, $urandom, 1'b0, 2'b01);
        cycle(1'b1, 32'd2, 32'h0BADBEEF, 1'b0, 2'b11);

        // Back-to-back full beats: one beat per lane per cycle.
        cycle(1'b0, 32'd0, '0, 1'b0, 2'b11);
        beats[0] = 0; beats[1] = 0;
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'd4, $urandom, 1'b0, 2'b11);
        beats[0] = 0; beats[1] = 0;
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'd0, '0, 1'b0, 2'b11);
        chk("b2b_beats_lane0", 64'(beats[0]), 64'd1);
        beats[0] = 0; beats[1] = 0;
        cycle(1'b1, 32'd4, $urandom, 1'b0, 2'b11);
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'd4, $urandom, 1'b0, 2'b11);
        chk("b2b_beats_lane0_run", 64'(beats[0]), 64'd8);
        chk("b2b_beats_lane1_run", 64'(beats[1]), 64'd8);

        // Overflow: count clamps to {2,2}, flag is sticky until reset.
        cycle(1'b1, 32'd7, 32'h01020304, 1'b0, 2'b11);
        cycle(1'b0, 32'd0, '0, 1'b0, 2'b00);
        chk("ovf_num0", 64'(out_num[0]), 64'd2);
        chk("ovf_num1", 64'(out_num[1]), 64'd2);
        cycle(1'b1, 32'd1, 32'h0, 1'b0, 2'b11);
        cycle(1'b0, 32'd0, '0, 1'b0, 2'b11);
        chk("ovf_sticky", 64'(err_overflow), 64'd1);
        do_reset();

        // Reset while lane0 holds a stalled beat: nothing stale afterwards.
        cycle(1'b1, 32'd2, 32'h00009988, 1'b0, 2'b00);
        cycle(1'b0, 32'd0, '0, 1'b0, 2'b00);
        do_reset();
        cycle(1'b0, 32'd0, '0, 1'b0, 2'b11);
        cycle(1'b1, 32'd3, 32'h44332211, 1'b1, 2'b11);
        cycle(1'b0, 32'd0, '0, 1'b0, 2'b11);

        // Randomized traffic, including counts that only overflow at full 32-bit width.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 39);
            if (r < 36)       rn = 32'(r % 5);
            else if (r < 38)  rn = 32'(5 + $urandom_range(0, 2));
            else if (r == 38) rn = 32'h8000_0002;
            else              rn = 32'hFFFF_FFFF;
            cycle($urandom_range(0, 3) != 0, rn, $urandom, $urandom_range(0, 3) == 0,
                  2'($urandom_range(0, 3)));
            if (i == 200) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/block_splitter.md
# block_splitter

Inverse of the two-input block shifter. Takes one packed word of up to 2·MAX_NUM_BLOCKS blocks plus a block count, and splits it into two lanes. Lane 0 gets the lowest blocks, up to MAX_NUM_BLOCKS of them. Lane 1 gets the remainder, re-based to bit 0. Each lane has an independent registered ready/valid output, so two downstream consumers can drain at different rates. It sits where a merged block stream must fan back out to two per-side pipelines.

## Interface
Parameters:
- BLOCK_SIZE, 64, bits per block
- MAX_NUM_BLOCKS, 1, maximum blocks per output lane; the input carries up to 2·MAX_NUM_BLOCKS blocks

Ports:
- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- in_ready  out  1  input accepted this cycle when in_valid & in_ready
- in_data  in  2·MAX_NUM_BLOCKS·BLOCK_SIZE  packed blocks; block k occupies bits [k·BLOCK_SIZE +: BLOCK_SIZE]
- in_valid  in  1  input beat valid
- in_num  in  32  number of valid blocks in in_data, starting at block 0
- in_last  in  1  final beat of a stream
- out_ready  in  [1:0]  per-lane consumer ready
- out_data  out  [1:0][MAX_NUM_BLOCKS·BLOCK_SIZE]  per-lane blocks
- out_valid  out  [1:0]  per-lane beat valid
- out_num  out  [1:0][31:0]  per-lane block count
- out_last  out  [1:0]  per-lane last flag
- err_overflow  out  1  sticky flag: an input beat had in_num > 2·MAX_NUM_BLOCKS

## Operation
- Lane k is **free** when ~out_valid[k] | out_ready[k].
- in_ready = rst_n & free[0] & free[1]. This is combinational from the lane registers and out_ready. No path from in_valid to in_ready.
- On accept, compute n = min(in_num, 2·MAX_NUM_BLOCKS). If in_num > 2·MAX_NUM_BLOCKS, set err_overflow.
- n0 = min(n, MAX_NUM_BLOCKS); n1 = n − n0.
- Lane 0 load:
  - out_num[0] ← n0
  - out_data[0] blocks 0..n0−1 ← input blocks 0..n0−1
  - out_valid[0] ← (n0 > 0) | in_last
  - out_last[0] ← in_last
- Lane 1 load:
  - out_num[1] ← n1
  - out_data[1] blocks 0..n1−1 ← input blocks MAX_NUM_BLOCKS..MAX_NUM_BLOCKS+n1−1
  - out_valid[1] ← (n1 > 0) | in_last
  - out_last[1] ← in_last
- Both lanes see last, so the merging shifter's AND of last flags round-trips.
- A lane not loaded on an accept, but free, clears out_valid. It keeps its data and num registers unless it was drained.
- A lane with out_valid & ~out_ready holds all of its outputs stable.
- An accept with n == 0 and ~in_last produces no output beat on either lane. The input is consumed.
- Lane state machine (per lane): EMPTY → FULL on accept with load; FULL → EMPTY on out_ready without a simultaneous accept; FULL → FULL on out_ready with a simultaneous accept that loads the lane.
- err_overflow clears only on reset.
- Widths: in_num is treated as unsigned 32-bit. The comparison with 2·MAX_NUM_BLOCKS is done at 32 bits, with no truncation.

## Timing
- Latency: 1 cycle from input accept to out_valid.
- Throughput: 1 beat per cycle when both out_ready are held high.
- Simultaneous drain and accept on the same lane in the same cycle: the new beat is registered, with no bubble.
- When one lane stalls, in_ready drops the same cycle. The other lane still drains its current beat and then goes EMPTY.
- Reset values, applied on a clock edge with rst_n low:
  - out_valid = 0, out_data = 0, out_num = 0, out_last = 0, err_overflow = 0.
  - in_ready = 0 while rst_n is low.
- Reset mid-transfer discards held beats. No partial beat is emitted after reset.

## Configuration
- BLOCK_SPLITTER_ZERO_FILL_EN defined: on every load, block slots at index ≥ out_num[k] in out_data[k] are driven to 0.
- Undefined: those slots carry the raw input bits at that position. They are don't-care to consumers, and the area is lower. Lane 1 still shifts by MAX_NUM_BLOCKS blocks.
- Out_num, valid, and last behaviour are identical in both builds.

## Test plan
- MAX_NUM_BLOCKS=2. Drive in_num=3, blocks A,B,C,X, last=0, both lanes ready → next cycle: lane0 out_num=2 with data A,B; lane1 out_num=1 with data C, and slot 1 = 0 when ZERO_FILL_EN is defined.
- Drive in_num=1 → lane0 valid with out_num=1, lane1 out_valid=0. Then drive in_num=0 with last=1 → both lanes valid, out_num=0, out_last=1.
- Hold out_ready[1]=0 with lane1 full → in_ready=0; lane0 drains once and then its out_valid=0; lane1 outputs stay stable. Release → in_ready=1 the same cycle.
- Both lanes ready, back-to-back beats for 8 cycles → 8 output beats per active lane on consecutive cycles, with no bubbles.
- Drive in_num=7 with MAX_NUM_BLOCKS=2 → err_overflow=1 and stays set, out_num = {2, 2}. Assert rst_n=0 for one edge → err_overflow=0 and all out_valid=0.
- Assert reset while lane0 is full and stalled → after release, no stale beat appears; the first new accept outputs correct data.
